// File: rtl/token_noc_arbiter.sv
// Time-slot round-robin arbiter sharing one NoC injection port between NUM_REQ
// requesters, with an in-order output FIFO, congestion counter and protocol-error flag.

module token_noc_lane (
  input  logic sel,
  input  logic grant_ok,
  input  logic valid,
  output logic ready,
  output logic err
);
  assign ready = sel & grant_ok;
  assign err   = valid & ~ready;
endmodule

module token_noc_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_val,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          noc_valid,
  output logic [DATA_W-1:0]             noc_val,
  output logic [ADDR_W-1:0]             noc_addr,
  input  logic                          noc_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              congest_cnt,
  input  logic                          clr_stats,
  output logic                          proto_err
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
  } pkt_t;

  logic [PW-1:0]                    ptr;
  logic [AW-1:0]                    wr_ptr, rd_ptr;
  logic [LW-1:0]                    level;
  pkt_t                             mem [FIFO_DEPTH];
  pkt_t                             head, push_pkt;
  logic [NUM_REQ-1:0][DATA_W-1:0]   val_arr;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   addr_arr;
  logic [NUM_REQ-1:0]               sel_vec, err_vec;
  logic                             grant_ok, push, pop, keep_nz;

  assign val_arr  = req_val;
  assign addr_arr = req_addr;

  // Reset gates the grant so req_ready drops immediately on async assertion.
  assign grant_ok = enable & reset & (level != LW'(FIFO_DEPTH));
  assign sel_vec  = NUM_REQ'(1) << ptr;

  token_noc_lane u_lane [NUM_REQ-1:0] (
    .sel      (sel_vec),
    .grant_ok (grant_ok),
    .valid    (req_valid),
    .ready    (req_ready),
    .err      (err_vec)
  );

  assign push     = |(req_ready & req_valid);
  assign pop      = noc_valid & noc_ready;
  assign push_pkt = '{addr: addr_arr[ptr], val: val_arr[ptr]};

  assign noc_valid  = (level != '0);
  assign noc_val    = head.val;
  assign noc_addr   = head.addr;
  assign fifo_level = level;

  // An older entry survives this edge, so the new head comes from memory;
  // otherwise a push into an emptying FIFO lands straight in the head register.
  assign keep_nz = (level > LW'(1)) | ((level == LW'(1)) & ~pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      head        <= '0;
      congest_cnt <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (enable) ptr <= (ptr == PW'(NUM_REQ-1)) ? '0 : ptr + PW'(1);
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
      if (keep_nz)   head <= mem[rd_ptr + AW'(pop)];
      else if (push) head <= push_pkt;
      if (clr_stats) begin
        congest_cnt <= '0;
        proto_err   <= 1'b0;
      end else begin
        if (|err_vec) proto_err <= 1'b1;
        if ((level == LW'(FIFO_DEPTH)) && (congest_cnt != '1))
          congest_cnt <= congest_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_pkt;
  end
endmodule
